// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/status bundle between the multicycle MIPS controller and its datapath
interface multicycle_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       PCen;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       Ori;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ALUControl;

  // Controller side: reads instruction fields and zero, drives every control input
  modport master (
    input  op, funct, zero,
    output PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, Ori, ALUSrcB, PCSrc, ALUControl
  );

  // Datapath side
  modport slave (
    output op, funct, zero,
    input  PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, Ori, ALUSrcB, PCSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM and ALU decoder for the 32-bit multicycle MIPS datapath
module multicycle_control #(
  parameter logic [5:0] ORI_OP  = 6'h0D,
  parameter logic [2:0] ALU_ADD = 3'b010,
  parameter logic [2:0] ALU_SUB = 3'b110,
  parameter logic [2:0] ALU_AND = 3'b000,
  parameter logic [2:0] ALU_OR  = 3'b001,
  parameter logic [2:0] ALU_SLT = 3'b111
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus,
  output logic [3:0]           state_o,
  output logic                 illegal_o
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8,
    IMMEX  = 4'd9,
    IMMWB  = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       illegal_next;

  logic       funct_ok;
  logic [2:0] funct_alu;

  logic       pc_en;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       memto_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic       ori_sel;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] alu_control;

  // State and illegal-pulse registers; reset aborts any instruction straight to FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      illegal_o <= 1'b0;
    end else begin
      state     <= state_next;
      illegal_o <= illegal_next;
    end
  end

  // R-type funct decode: ALU operation and whether the funct is one we implement
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Next-state and Moore outputs per state; PCen in BRANCH additionally follows zero
  always_comb begin
    state_next   = FETCH;
    illegal_next = 1'b0;
    pc_en        = 1'b0;
    iord         = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = 1'b0;
    memto_reg    = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    ori_sel      = 1'b0;
    alu_src_b    = 2'b00;
    pc_src       = 2'b00;
    alu_control  = ALU_ADD;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b01;
        pc_en      = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        // Branch target (PC+4 + offset<<2) lands in ALUOut for a possible BRANCH
        alu_src_b = 2'b11;
        if (bus.op == OP_LW || bus.op == OP_SW) begin
          state_next = MEMADR;
        end else if (bus.op == OP_RTYPE) begin
          if (funct_ok) state_next = RTEX;
          else          illegal_next = 1'b1;
        end else if (bus.op == OP_BEQ || bus.op == OP_BNE) begin
          state_next = BRANCH;
        end else if (bus.op == OP_ADDI || bus.op == ORI_OP) begin
          state_next = IMMEX;
        end else if (bus.op == OP_J) begin
          state_next = JUMP;
        end else begin
          illegal_next = 1'b1;
        end
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord       = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        memto_reg = 1'b1;
        reg_write = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      RTEX: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        state_next  = RTWB;
      end
      RTWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        if (bus.op == OP_BEQ)      pc_en = bus.zero;
        else if (bus.op == OP_BNE) pc_en = ~bus.zero;
      end
      IMMEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = IMMWB;
        if (bus.op == ORI_OP) begin
          alu_control = ALU_OR;
          ori_sel     = 1'b1;
        end
      end
      IMMWB: begin
        // ALUOut already holds the result, so the immediate mux is left at its default
        reg_write = 1'b1;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // Write-type enables are held off for as long as reset is low
  assign bus.PCen       = pc_en & reset;
  assign bus.IRWrite    = ir_write & reset;
  assign bus.MemWrite   = mem_write & reset;
  assign bus.RegWrite   = reg_write & reset;
  assign bus.IorD       = iord;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = memto_reg;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.Ori        = ori_sel;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.PCSrc      = pc_src;
  assign bus.ALUControl = alu_control;
  assign state_o        = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for the multicycle MIPS control FSM
module tb_multicycle_control;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] state_o;
  logic       illegal_o;
  int         vectors;
  int         miscompares;
  logic       pend_ill;
  exp_t       sb[$];
  logic [15:0] act_ctl;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_o   (state_o),
    .illegal_o (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act_ctl = {bus.PCen, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                    bus.RegWrite, bus.ALUSrcA, bus.Ori, bus.ALUSrcB, bus.PCSrc, bus.ALUControl};

  function automatic logic [15:0] cv(input logic pcen, input logic iord, input logic mw,
                                     input logic irw, input logic rd, input logic m2r,
                                     input logic rw, input logic sa, input logic ori,
                                     input logic [1:0] srcb, input logic [1:0] ps,
                                     input logic [2:0] alu);
    return {pcen, iord, mw, irw, rd, m2r, rw, sa, ori, srcb, ps, alu};
  endfunction

  task automatic push(input string nm, input logic [3:0] st, input logic [15:0] c);
    exp_t e;
    e.name = nm;
    e.st   = st;
    e.ctl  = c;
    e.ill  = pend_ill;
    pend_ill = 1'b0;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: one expected record per cycle, sampled just after the falling edge
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (state_o !== e.st || act_ctl !== e.ctl || illegal_o !== e.ill) begin
        miscompares++;
        $display("FAIL %s: got state %0d ctl %h ill %b, want state %0d ctl %h ill %b",
                 e.name, state_o, act_ctl, illegal_o, e.st, e.ctl, e.ill);
      end
    end
  end

  task automatic wait_sb();
    for (int i = 0; i < 64 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_timeout: got %0d entries left, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Drive one instruction starting in its FETCH cycle and queue its cycle-by-cycle controls
  task automatic issue(input int kind, input logic z);
    logic [5:0] rt_funct [0:4];
    logic [2:0] rt_alu   [0:4];
    logic [15:0] c_f;
    logic [15:0] c_d;
    rt_funct = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    rt_alu   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    c_f = cv(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
    c_d = cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010);
    bus.zero  = z;
    bus.funct = 6'($urandom_range(0, 63));
    case (kind)
      0: begin
        bus.op = 6'h23;
        push("lw fetch", 4'd0, c_f);
        push("lw decode", 4'd1, c_d);
        push("lw memadr", 4'd2, cv(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b010));
        push("lw memrd", 4'd3, cv(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010));
        push("lw memwb", 4'd4, cv(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b010));
      end
      1: begin
        bus.op = 6'h2B;
        push("sw fetch", 4'd0, c_f);
        push("sw decode", 4'd1, c_d);
        push("sw memadr", 4'd2, cv(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b010));
        push("sw memwr", 4'd5, cv(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010));
      end
      2, 3, 4, 5, 6: begin
        bus.op    = 6'h00;
        bus.funct = rt_funct[kind-2];
        push("rt fetch", 4'd0, c_f);
        push("rt decode", 4'd1, c_d);
        push("rt rtex", 4'd6, cv(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, rt_alu[kind-2]));
        push("rt rtwb", 4'd7, cv(0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010));
      end
      7, 8: begin
        bus.op = (kind == 7) ? 6'h04 : 6'h05;
        push("br fetch", 4'd0, c_f);
        push("br decode", 4'd1, c_d);
        push((kind == 7) ? "beq branch" : "bne branch", 4'd8,
             cv((kind == 7) ? z : ~z, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 3'b110));
      end
      9, 10: begin
        bus.op = (kind == 9) ? 6'h08 : 6'h0D;
        push("imm fetch", 4'd0, c_f);
        push("imm decode", 4'd1, c_d);
        push((kind == 9) ? "addi immex" : "ori immex", 4'd9,
             cv(0, 0, 0, 0, 0, 0, 0, 1, (kind == 10), 2'b10, 2'b00,
                (kind == 9) ? 3'b010 : 3'b001));
        push("imm immwb", 4'd10, cv(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010));
      end
      11: begin
        bus.op = 6'h02;
        push("j fetch", 4'd0, c_f);
        push("j decode", 4'd1, c_d);
        push("j jump", 4'd11, cv(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010));
      end
      default: begin
        if (kind == 12) begin
          bus.op = 6'h3E;
        end else begin
          bus.op    = 6'h00;
          bus.funct = 6'h3F;
        end
        push("ill fetch", 4'd0, c_f);
        push("ill decode", 4'd1, c_d);
        pend_ill = 1'b1;
      end
    endcase
    wait_sb();
  endtask

  task automatic test_reset();
    push("reset hold", 4'd0, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010));
    wait_sb();
    reset = 1'b1;
  endtask

  task automatic test_lw();
    issue(0, 1'b0);
  endtask

  task automatic test_sw();
    issue(1, 1'b1);
  endtask

  task automatic test_rtype();
    for (int k = 2; k <= 6; k++) issue(k, 1'b0);
  endtask

  task automatic test_branch();
    issue(7, 1'b1);
    issue(7, 1'b0);
    issue(8, 1'b1);
    issue(8, 1'b0);
  endtask

  task automatic test_imm();
    issue(10, 1'b0);
    issue(9, 1'b0);
  endtask

  task automatic test_jump();
    issue(11, 1'b0);
  endtask

  task automatic test_illegal();
    issue(12, 1'b0);
    issue(13, 1'b0);
    issue(11, 1'b0);
  endtask

  task automatic test_reset_midway();
    bus.op = 6'h2B;
    push("mid fetch", 4'd0, cv(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010));
    push("mid decode", 4'd1, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010));
    push("mid memadr", 4'd2, cv(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b010));
    wait_sb();
    #1;
    vectors++;
    if (bus.MemWrite !== 1'b1 || state_o !== 4'd5) begin
      miscompares++;
      $display("FAIL mid_memwr: got MemWrite %b state %0d, want 1 5", bus.MemWrite, state_o);
    end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (bus.MemWrite !== 1'b0 || state_o !== 4'd0 || bus.PCen !== 1'b0 ||
        bus.IRWrite !== 1'b0 || bus.RegWrite !== 1'b0 || illegal_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_abort: got MemWrite %b state %0d PCen %b IRWrite %b RegWrite %b, want 0 0 0 0 0",
               bus.MemWrite, state_o, bus.PCen, bus.IRWrite, bus.RegWrite);
    end
    @(negedge clk);
    reset = 1'b1;
    issue(1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) issue(int'($urandom_range(0, 13)), 1'($urandom_range(0, 1)));
    issue(0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pend_ill    = 1'b0;
    reset       = 1'b0;
    bus.op      = 6'h23;
    bus.funct   = 6'h00;
    bus.zero    = 1'b0;
    @(negedge clk);
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_branch();
    test_imm();
    test_jump();
    test_illegal();
    test_reset_midway();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
